// File: rtl/mux_arb_pkg.sv
// +--------------------------------------------------------------------+
// | mux_arb_pkg: shared types and defaults for the 2-way mux arbiter   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam int HOLD_MAX_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/mux_sel_arb_2.sv
// +--------------------------------------------------------------------+
// | mux_sel_arb_2: two-requester round-robin arbiter with packet lock, |
// | driving the select of a downstream 2:1 mux.  Revision: 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module mux_sel_arb_2
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic last0,
  input  logic last1,
  input  logic accept,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic grant_valid
);

  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(HOLD_MAX - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_prio;
  logic             w_prio_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Owner-relative views so BUSY0 and BUSY1 share one release path.
  logic w_own;
  logic w_req_own;
  logic w_req_oth;
  logic w_last_own;

  assign w_own      = (r_state == BUSY1);
  assign w_req_own  = w_own ? req1  : req0;
  assign w_req_oth  = w_own ? req0  : req1;
  assign w_last_own = w_own ? last1 : last0;

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (req0 && req1)
          w_state_nxt = r_prio ? BUSY1 : BUSY0;
        else if (req0)
          w_state_nxt = BUSY0;
        else if (req1)
          w_state_nxt = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (w_req_own && accept) begin
          if (w_last_own || (r_beat_cnt == C_LAST_BEAT)) begin
            w_cnt_nxt  = '0;
            w_prio_nxt = ~w_own;
            // The owner is requesting on a beat, so without a waiting peer it keeps the mux.
            if (w_req_oth)
              w_state_nxt = w_own ? BUSY0 : BUSY1;
          end else begin
            w_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_beat_cnt  <= '0;
      sel         <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      grant_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prio      <= w_prio_nxt;
      r_beat_cnt  <= w_cnt_nxt;
      gnt0        <= (w_state_nxt == BUSY0);
      gnt1        <= (w_state_nxt == BUSY1);
      grant_valid <= (w_state_nxt != IDLE);
      // Select keeps pointing at the last owner while idle.
      if (w_state_nxt != IDLE)
        sel <= (w_state_nxt == BUSY1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arb_2.sv
// +--------------------------------------------------------------------+
// | tb_mux_sel_arb_2: directed + random bench with a behavioural model |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mux_sel_arb_2;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b1, req1 = 1'b1, last0 = 1'b0, last1 = 1'b0, accept = 1'b0;
  logic sel, gnt0, gnt1, grant_valid;

  int checks = 0;
  int errors = 0;

  mux_sel_arb_2 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .last0(last0), .last1(last1),
    .accept(accept), .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  // Model: who owns the mux (-1 = nobody), beats taken in this grant, who is favoured.
  int m_owner = -1;
  int m_beats = 0;
  int m_prio  = 0;
  int m_sel   = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int k, other;
    bit rk, lk, ro;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_prio = 0; m_sel = 0; m_valid = 1;
    end else if (m_owner < 0) begin
      if (req0 && req1) m_owner = m_prio;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
    end else begin
      k     = m_owner;
      other = 1 - k;
      rk    = (k == 0) ? req0 : req1;
      lk    = (k == 0) ? last0 : last1;
      ro    = (k == 0) ? req1 : req0;
      if (rk && accept) begin
        m_beats = m_beats + 1;
        if (lk || m_beats == HOLD) begin
          m_beats = 0;
          m_prio  = other;
          if (ro)      m_owner = other;
          else if (rk) m_owner = k;
          else         m_owner = -1;
        end
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sel",  {31'd0, sel},         m_sel);
      chk("model_gnt0", {31'd0, gnt0},        (m_owner == 0) ? 32'd1 : 32'd0);
      chk("model_gnt1", {31'd0, gnt1},        (m_owner == 1) ? 32'd1 : 32'd0);
      chk("model_gv",   {31'd0, grant_valid}, (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("mutex",      {31'd0, gnt0 & gnt1}, 32'd0);
    end
  end

  task automatic drive(input logic r, input logic a, input logic b,
                       input logic la, input logic lb, input logic acc);
    @(negedge clk);
    rst = r; req0 = a; req1 = b; last0 = la; last1 = lb; accept = acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both requesting
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_gnt1", {31'd0, gnt1}, 0);
    chk("rst_gv",   {31'd0, grant_valid}, 0);
    chk("rst_sel",  {31'd0, sel}, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk("first_gnt0", {31'd0, gnt0}, 1);

    // Contention with last on every beat alternates each cycle
    drive(0, 1, 1, 1, 1, 1); chk("alt_sel1", {31'd0, sel}, 1);
    drive(0, 1, 1, 1, 1, 1); chk("alt_sel2", {31'd0, sel}, 0);
    drive(0, 1, 1, 1, 1, 1); chk("alt_sel3", {31'd0, sel}, 1);
    drive(0, 1, 1, 1, 1, 1); chk("alt_sel4", {31'd0, sel}, 0);

    // Lone requester: 3-beat packet, then immediate re-grant
    drive(0, 1, 0, 0, 0, 1); chk("single_b1", {31'd0, gnt0}, 1);
    drive(0, 1, 0, 0, 0, 1); chk("single_b2", {31'd0, gnt0}, 1);
    drive(0, 1, 0, 1, 0, 1); chk("single_regrant", {31'd0, gnt0}, 1);
    chk("single_gv", {31'd0, grant_valid}, 1);

    // Beat limit: 4 beats without last, then handover
    drive(0, 1, 1, 0, 0, 1); chk("limit_b1", {31'd0, gnt0}, 1);
    drive(0, 1, 1, 0, 0, 1); chk("limit_b2", {31'd0, gnt0}, 1);
    drive(0, 1, 1, 0, 0, 1); chk("limit_b3", {31'd0, gnt0}, 1);
    drive(0, 1, 1, 0, 0, 1); chk("limit_handover", {31'd0, gnt1}, 1);

    // Backpressure: accept 1,0,0,1 with last on the 2nd accepted beat
    drive(0, 1, 1, 0, 0, 1); chk("bp_c1", {31'd0, gnt1}, 1);
    drive(0, 1, 1, 0, 1, 0); chk("bp_c2", {31'd0, gnt1}, 1);
    drive(0, 1, 1, 0, 1, 0); chk("bp_c3", {31'd0, gnt1}, 1);
    drive(0, 1, 1, 0, 1, 1); chk("bp_release", {31'd0, gnt0}, 1);

    // Owner bubble: grant held while the other waits
    drive(0, 0, 1, 0, 0, 1); chk("bubble1", {31'd0, gnt0}, 1);
    drive(0, 0, 1, 0, 0, 1); chk("bubble2", {31'd0, gnt1}, 0);
    drive(0, 1, 1, 1, 0, 1); chk("bubble_end", {31'd0, gnt1}, 1);

    // Reset mid-packet restores requester-0 priority
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 1);
    chk("midrst_gnt1", {31'd0, gnt1}, 0);
    chk("midrst_gv",   {31'd0, grant_valid}, 0);
    drive(0, 1, 1, 0, 0, 0);
    chk("midrst_prio", {31'd0, gnt0}, 1);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0),
            ($urandom_range(9) < 7), ($urandom_range(9) < 7),
            ($urandom_range(9) < 3), ($urandom_range(9) < 3),
            ($urandom_range(9) < 7));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
